// File: rtl/otter_iobus_timer.sv
// otter_iobus_timer: memory-mapped prescaled timer/compare responder on the OTTER IOBUS
module otter_iobus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int          PS_WIDTH  = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);
    typedef enum logic {STOP, RUN} state_t;
    state_t state;
    logic en, auto_rl, irq_en, match;
    logic [PS_WIDTH-1:0] prescale, ps_cnt;
    logic [31:0] compare, count;
    logic sel, we, wr_ctrl, wr_cnt, tick, hit;
    logic [2:0] off;
    logic unused;

    assign sel = IOBUS_ADDR[31:5] == BASE_ADDR[31:5];
    assign off = IOBUS_ADDR[4:2];
    assign we = IOBUS_WR && sel;
    assign wr_ctrl = we && off == 3'd0;
    assign wr_cnt = we && off == 3'd3;
    assign tick = state == RUN && ps_cnt == prescale;
    // A CPU load of COUNT on a tick edge suppresses both the increment and the compare.
    assign hit = tick && !wr_cnt && count == compare;
    assign INTR = match & irq_en;
    assign unused = ^{IOBUS_ADDR[1:0], IOBUS_OUT};

    always_comb begin
        IOBUS_IN = !sel       ? 32'h0 :
                   off == 3'd0 ? {29'h0, irq_en, auto_rl, en} :
                   off == 3'd1 ? 32'(prescale) :
                   off == 3'd2 ? compare :
                   off == 3'd3 ? count :
                   off == 3'd4 ? {31'h0, match} : 32'h0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= STOP;
            {irq_en, auto_rl, en} <= 3'b000;
            match <= 1'b0;
            prescale <= '0;
            ps_cnt <= '0;
            compare <= '0;
            count <= '0;
        end else begin
            if (state == RUN)
                ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
            // A CTRL write overrides the one-shot auto-stop on the same edge.
            if (wr_ctrl) begin
                {irq_en, auto_rl, en} <= IOBUS_OUT[2:0];
                state <= IOBUS_OUT[0] ? RUN : STOP;
                if (state == STOP && IOBUS_OUT[0])
                    ps_cnt <= '0;
            end else if (hit && !auto_rl) begin
                en <= 1'b0;
                state <= STOP;
            end
            if (we && off == 3'd1)
                prescale <= IOBUS_OUT[PS_WIDTH-1:0];
            if (we && off == 3'd2)
                compare <= IOBUS_OUT;
            if (wr_cnt)
                count <= IOBUS_OUT;
            else if (tick)
                count <= hit ? (auto_rl ? '0 : count) : count + 1'b1;
            if (hit)
                match <= 1'b1;
            else if (we && off == 3'd4 && IOBUS_OUT[0])
                match <= 1'b0;
        end
    end
endmodule

// File: tb/tb_otter_iobus_timer.sv
// tb_otter_iobus_timer: directed bus transactions with a queued scoreboard checked by a monitor
module tb_otter_iobus_timer;
    localparam logic [31:0] A_CTRL = 32'h1100_0100;
    localparam logic [31:0] A_PS   = 32'h1100_0104;
    localparam logic [31:0] A_CMP  = 32'h1100_0108;
    localparam logic [31:0] A_CNT  = 32'h1100_010C;
    localparam logic [31:0] A_ST   = 32'h1100_0110;

    logic CLK = 1'b0, RST = 1'b1, IOBUS_WR = 1'b0, INTR;
    logic [31:0] IOBUS_ADDR = 32'h0, IOBUS_OUT = 32'h0, IOBUS_IN;
    logic mon_v = 1'b0;
    int checks = 0, failures = 0;

    typedef struct {
        string       name;
        logic [31:0] d;
        logic        i;
    } exp_t;
    exp_t q[$];
    exp_t e;

    otter_iobus_timer dut (
        .CLK(CLK), .RST(RST), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .INTR(INTR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (mon_v) begin
            if (q.size() == 0) begin
                failures++;
                $display("FAIL monitor: no expected entry queued");
            end else begin
                e = q.pop_front();
                checks++;
                if (IOBUS_IN !== e.d) begin
                    failures++;
                    $display("FAIL %s data: got %h want %h", e.name, IOBUS_IN, e.d);
                end
                checks++;
                if (INTR !== e.i) begin
                    failures++;
                    $display("FAIL %s intr: got %b want %b", e.name, INTR, e.i);
                end
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT = d;
        IOBUS_WR = 1'b1;
        @(posedge CLK);
        #1 IOBUS_WR = 1'b0;
    endtask

    task automatic rd(input string n, input logic [31:0] a, input logic [31:0] d, input logic i);
        exp_t x;
        x.name = n;
        x.d = d;
        x.i = i;
        q.push_back(x);
        IOBUS_ADDR = a;
        mon_v = 1'b1;
        @(posedge CLK);
        #1 mon_v = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        @(posedge CLK);
        #1;
        rd("rst_hold_ctrl", A_CTRL, 32'h0, 1'b0);
        RST = 1'b0;
        rd("rst_ctrl", A_CTRL, 32'h0, 1'b0);
        rd("rst_cnt", A_CNT, 32'h0, 1'b0);

        // auto-reload, every cycle a tick
        wr(A_PS, 32'h0);
        wr(A_CMP, 32'h3);
        wr(A_CTRL, 32'h7);
        rd("ar_cnt0", A_CNT, 32'h0, 1'b0);
        rd("ar_cnt1", A_CNT, 32'h1, 1'b0);
        rd("ar_cnt2", A_CNT, 32'h2, 1'b0);
        rd("ar_cnt3", A_CNT, 32'h3, 1'b0);
        rd("ar_match", A_CNT, 32'h0, 1'b1);
        wr(A_ST, 32'h1);
        wr(A_CTRL, 32'h4);
        rd("ar_w1c", A_ST, 32'h0, 1'b0);
        rd("ar_ctrl", A_CTRL, 32'h4, 1'b0);
        rd("ar_hold", A_CNT, 32'h3, 1'b0);

        // one-shot, tick every 5 cycles
        wr(A_PS, 32'h4);
        wr(A_CMP, 32'h2);
        wr(A_CNT, 32'h0);
        wr(A_CTRL, 32'h5);
        idle(4);
        rd("os_pre_tick", A_CNT, 32'h0, 1'b0);
        rd("os_tick1", A_CNT, 32'h1, 1'b0);
        idle(8);
        rd("os_pre_match", A_CNT, 32'h2, 1'b0);
        rd("os_en_clr", A_CTRL, 32'h4, 1'b1);
        rd("os_cnt", A_CNT, 32'h2, 1'b1);
        rd("os_st", A_ST, 32'h1, 1'b1);
        idle(10);
        rd("os_hold", A_CNT, 32'h2, 1'b1);

        // COUNT write on a tick edge, W1C on a match edge
        wr(A_ST, 32'h1);
        wr(A_PS, 32'h0);
        wr(A_CMP, 32'd100);
        wr(A_CNT, 32'h0);
        wr(A_CTRL, 32'h1);
        wr(A_CNT, 32'h10);
        rd("col_cnt_wr", A_CNT, 32'h10, 1'b0);
        rd("col_cnt_inc", A_CNT, 32'h11, 1'b0);
        wr(A_CTRL, 32'h0);
        wr(A_CMP, 32'h2);
        wr(A_CNT, 32'h0);
        wr(A_CTRL, 32'h7);
        idle(2);
        wr(A_ST, 32'h1);
        rd("col_w1c_set", A_ST, 32'h1, 1'b1);
        wr(A_CTRL, 32'h0);

        // wrap without flag
        wr(A_ST, 32'h1);
        wr(A_CMP, 32'h5);
        wr(A_CNT, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h1);
        rd("wr_max", A_CNT, 32'hFFFF_FFFF, 1'b0);
        rd("wr_zero", A_CNT, 32'h0, 1'b0);
        rd("wr_nomatch", A_ST, 32'h0, 1'b0);
        idle(3);
        rd("wr_pre", A_ST, 32'h0, 1'b0);
        rd("wr_match", A_ST, 32'h1, 1'b0);
        rd("wr_ctrl", A_CTRL, 32'h0, 1'b0);
        rd("wr_cnt", A_CNT, 32'h5, 1'b0);

        // decode
        rd("dec_low", 32'h1100_0014, 32'h0, 1'b0);
        rd("dec_hole", 32'h1100_0114, 32'h0, 1'b0);
        rd("dec_out", 32'h1100_0200, 32'h0, 1'b0);
        rd("dec_lsb", 32'h1100_010B, 32'h5, 1'b0);
        wr(32'h1100_0208, 32'hDEAD);
        wr(32'h1100_0200, 32'h7);
        wr(32'h1100_0114, 32'h1);
        rd("dec_cmp", A_CMP, 32'h5, 1'b0);
        rd("dec_ctrl", A_CTRL, 32'h0, 1'b0);

        // reset mid-run with INTR high
        wr(A_ST, 32'h1);
        wr(A_CMP, 32'h0);
        wr(A_CNT, 32'h0);
        wr(A_CTRL, 32'h7);
        rd("mr_pre", A_ST, 32'h0, 1'b0);
        rd("mr_match", A_ST, 32'h1, 1'b1);
        RST = 1'b1;
        rd("mr_async", A_CTRL, 32'h0, 1'b0);
        RST = 1'b0;
        rd("mr_ctrl", A_CTRL, 32'h0, 1'b0);
        rd("mr_ps", A_PS, 32'h0, 1'b0);
        rd("mr_cmp", A_CMP, 32'h0, 1'b0);
        rd("mr_st", A_ST, 32'h0, 1'b0);
        idle(3);
        rd("mr_cnt", A_CNT, 32'h0, 1'b0);

        @(negedge CLK);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard: %0d entries left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
